// File: rtl/vc_queue_domain_arb.sv
// Two-domain enqueue arbiter in front of a single-label vc_Queue: serves one domain at a time,
// bounds bursts while the other domain waits, and drains the queue empty before relabelling it.
module vc_queue_domain_arb #(
    parameter  int p_msg_nbits  = 32,
    parameter  int p_num_msgs   = 2,
    parameter  int p_max_burst  = 4,
    localparam int c_addr_nbits = $clog2(p_num_msgs)
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   req0_val,
    output logic                   req0_rdy,
    input  logic [p_msg_nbits-1:0] req0_msg,

    input  logic                   req1_val,
    output logic                   req1_rdy,
    input  logic [p_msg_nbits-1:0] req1_msg,

    output logic                   q_domain,
    output logic                   q_enq_val,
    input  logic                   q_enq_rdy,
    output logic [p_msg_nbits-1:0] q_enq_msg,
    input  logic [c_addr_nbits:0]  q_num_free_entries,

    output logic                   draining
);

    localparam int                        c_burst_nbits = $clog2(p_max_burst + 1);
    localparam logic [c_burst_nbits-1:0]  c_burst_max   = c_burst_nbits'(p_max_burst);
    localparam logic [c_addr_nbits:0]     c_q_empty     = (c_addr_nbits + 1)'(p_num_msgs);

    typedef enum logic {
        SERVE = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                   r_state;
    logic                     r_cur;
    logic [c_burst_nbits-1:0] r_burst;

    logic w_cur_val;
    logic w_oth_val;
    logic w_quota_hit;
    logic w_switch_req;
    logic w_serve;
    logic w_grant;
    logic w_fire;
    logic w_q_empty;

    function automatic logic [c_burst_nbits-1:0] burst_sat_inc(input logic [c_burst_nbits-1:0] b);
        return (b == c_burst_max) ? b : b + c_burst_nbits'(1);
    endfunction

    always_comb begin
        w_cur_val    = r_cur ? req1_val : req0_val;
        w_oth_val    = r_cur ? req0_val : req1_val;
        w_quota_hit  = (r_burst == c_burst_max) && w_oth_val;
        w_switch_req = w_oth_val && (!w_cur_val || w_quota_hit);
        w_serve      = (r_state == SERVE);
        w_q_empty    = (q_num_free_entries == c_q_empty);
        // A quota-triggered switch blocks the enqueue in the same cycle.
        w_grant      = w_serve && q_enq_rdy && !w_quota_hit;
        w_fire       = w_grant && w_cur_val;
    end

    always_comb begin
        req0_rdy  = w_grant && !r_cur;
        req1_rdy  = w_grant && r_cur;
        q_enq_val = w_serve && w_cur_val && !w_quota_hit;
        q_enq_msg = '0;
        if (w_serve) begin
            q_enq_msg = r_cur ? req1_msg : req0_msg;
        end
        q_domain  = r_cur;
        draining  = (r_state == DRAIN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SERVE;
            r_cur   <= 1'b0;
            r_burst <= '0;
        end else begin
            case (r_state)
                SERVE: begin
                    if (w_fire) begin
                        r_burst <= burst_sat_inc(r_burst);
                    end
                    if (w_switch_req) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Relabel only once the queue holds nothing of the old domain.
                    if (w_q_empty) begin
                        r_cur   <= !r_cur;
                        r_burst <= '0;
                        r_state <= SERVE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vc_queue_domain_arb.sv
// Bench for vc_queue_domain_arb: two instances (burst 4 and burst 1), each with a behavioural
// two-entry queue and a rule-level reference model of the arbitration policy.
module tb_vc_queue_domain_arb;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic        v0  [2];
    logic        v1  [2];
    logic [31:0] m0  [2];
    logic [31:0] m1  [2];
    logic        deq [2];
    int          cnt [2];

    logic        r0r [2];
    logic        r1r [2];
    logic        qd  [2];
    logic        qv  [2];
    logic [31:0] qm  [2];
    logic        dr  [2];
    logic        qr  [2];
    logic [1:0]  fe  [2];

    assign qr[0] = (cnt[0] < 2);
    assign qr[1] = (cnt[1] < 2);
    assign fe[0] = 2'(2 - cnt[0]);
    assign fe[1] = 2'(2 - cnt[1]);

    vc_queue_domain_arb #(.p_msg_nbits(32), .p_num_msgs(2), .p_max_burst(4)) dut0 (
        .clk(clk), .reset(rst[0]),
        .req0_val(v0[0]), .req0_rdy(r0r[0]), .req0_msg(m0[0]),
        .req1_val(v1[0]), .req1_rdy(r1r[0]), .req1_msg(m1[0]),
        .q_domain(qd[0]), .q_enq_val(qv[0]), .q_enq_rdy(qr[0]), .q_enq_msg(qm[0]),
        .q_num_free_entries(fe[0]), .draining(dr[0])
    );

    vc_queue_domain_arb #(.p_msg_nbits(32), .p_num_msgs(2), .p_max_burst(1)) dut1 (
        .clk(clk), .reset(rst[1]),
        .req0_val(v0[1]), .req0_rdy(r0r[1]), .req0_msg(m0[1]),
        .req1_val(v1[1]), .req1_rdy(r1r[1]), .req1_msg(m1[1]),
        .q_domain(qd[1]), .q_enq_val(qv[1]), .q_enq_rdy(qr[1]), .q_enq_msg(qm[1]),
        .q_num_free_entries(fe[1]), .draining(dr[1])
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: which domain owns the queue, whether it is being emptied, and how
    // many enqueues the owner has had since it took over (capped at its burst limit).
    bit md   [2];
    bit mdr  [2];
    int mrun [2];
    int maxb [2];
    bit qdom [2];

    int fdom0[$];
    int fcyc0[$];
    int fdom1[$];
    int fcyc1[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic cycle();
        bit          cv, ov, cap, ev, er;
        logic [31:0] ectl, actl, em;
        bit          fire [2];
        bit          deqok[2];
        bit          dsnap[2];
        bit          nmd  [2];
        bit          nmdr [2];
        int          nrun [2];
        #1;
        for (int k = 0; k < 2; k++) begin
            cv   = md[k] ? v1[k] : v0[k];
            ov   = md[k] ? v0[k] : v1[k];
            cap  = (mrun[k] >= maxb[k]) && ov;
            ev   = !mdr[k] && cv && !cap;
            er   = !mdr[k] && (cnt[k] < 2) && !cap;
            ectl = 32'({md[k], mdr[k], er && !md[k], er && md[k], ev});
            em   = mdr[k] ? 32'h0 : (md[k] ? m1[k] : m0[k]);
            if (!rst[k]) begin
                actl = 32'({qd[k], dr[k], r0r[k], r1r[k], qv[k]});
                chk($sformatf("i%0d_ctl", k), actl, ectl);
                chk($sformatf("i%0d_msg", k), qm[k], em);
            end
            fire[k]  = qv[k] && (cnt[k] < 2);
            deqok[k] = deq[k] && (cnt[k] > 0);
            dsnap[k] = qd[k];
            if (fire[k] && !rst[k] && cnt[k] > 0)
                chk($sformatf("i%0d_mix", k), 32'(qd[k]), 32'(qdom[k]));
            nmd[k]  = md[k];
            nmdr[k] = mdr[k];
            nrun[k] = mrun[k];
            if (rst[k]) begin
                nmd[k]  = 1'b0;
                nmdr[k] = 1'b0;
                nrun[k] = 0;
            end else if (mdr[k]) begin
                if (cnt[k] == 0) begin
                    nmd[k]  = !md[k];
                    nmdr[k] = 1'b0;
                    nrun[k] = 0;
                end
            end else begin
                if (ev && cnt[k] < 2 && mrun[k] < maxb[k]) nrun[k] = mrun[k] + 1;
                if (ov && (!cv || cap)) nmdr[k] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (rst[k]) begin
                cnt[k] = 0;
            end else begin
                cnt[k] = cnt[k] - int'(deqok[k]) + int'(fire[k]);
                if (fire[k]) begin
                    qdom[k] = dsnap[k];
                    if (k == 0) begin
                        fdom0.push_back(int'(dsnap[k]));
                        fcyc0.push_back(cyc);
                    end else begin
                        fdom1.push_back(int'(dsnap[k]));
                        fcyc1.push_back(cyc);
                    end
                end
            end
            md[k]   = nmd[k];
            mdr[k]  = nmdr[k];
            mrun[k] = nrun[k];
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        int exp2 [8];
        exp2 = '{0, 0, 0, 0, 1, 1, 1, 1};
        maxb = '{4, 1};
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; v0[k] = 1'b0; v1[k] = 1'b0;
            m0[k] = 32'h0; m1[k] = 32'h0; deq[k] = 1'b1; cnt[k] = 0;
            md[k] = 1'b0; mdr[k] = 1'b0; mrun[k] = 0; qdom[k] = 1'b0;
        end
        repeat (2) cycle();
        rst[0] = 1'b0; rst[1] = 1'b0;

        // Instance 1: both requesters continuously valid with burst limit 1.
        v0[1] = 1'b1; v1[1] = 1'b1; m0[1] = 32'h100; m1[1] = 32'h200;

        // Domain 0 alone: eight back-to-back enqueues.
        fdom0.delete(); fcyc0.delete();
        for (int i = 0; i < 8; i++) begin
            v0[0] = 1'b1; m0[0] = 32'hA0 + 32'(i);
            cycle();
        end
        v0[0] = 1'b0;
        cycle();
        chk("p1_count", 32'(fdom0.size()), 32'd8);
        chk("p1_span", (fdom0.size() == 8) ? 32'(fcyc0[7] - fcyc0[0]) : 32'hFFFF, 32'd7);
        chk("p1_dom", 32'(qd[0]), 32'd0);

        // Both valid, burst 4: four of domain 0, drain, then four of domain 1.
        rst[0] = 1'b1; cycle(); rst[0] = 1'b0;
        fdom0.delete(); fcyc0.delete();
        v0[0] = 1'b1; v1[0] = 1'b1; m1[0] = 32'hB0;
        repeat (20) cycle();
        for (int i = 0; i < 8; i++)
            chk($sformatf("p2_seq%0d", i), 32'(qat(fdom0, i)), 32'(exp2[i]));

        // Full queue with stalled consumer, then domain 1 asks.
        rst[0] = 1'b1; cycle(); rst[0] = 1'b0;
        v1[0] = 1'b0; v0[0] = 1'b1; deq[0] = 1'b0;
        repeat (4) cycle();
        chk("p3_full", 32'(cnt[0]), 32'd2);
        v0[0] = 1'b0; v1[0] = 1'b1;
        repeat (5) cycle();
        chk("p3_drain", 32'(dr[0]), 32'd1);
        chk("p3_noenq", 32'(qv[0]), 32'd0);
        deq[0] = 1'b1;
        repeat (4) cycle();
        chk("p3_dom", 32'(qd[0]), 32'd1);

        // One-cycle pulse of domain 1 while domain 0 idles, then domain 0 returns.
        rst[0] = 1'b1; cycle(); rst[0] = 1'b0;
        v0[0] = 1'b0; v1[0] = 1'b0;
        repeat (2) cycle();
        v1[0] = 1'b1; cycle(); v1[0] = 1'b0;
        repeat (4) cycle();
        chk("p4_dom1", 32'(qd[0]), 32'd1);
        v0[0] = 1'b1; m0[0] = 32'hC0;
        repeat (4) cycle();
        chk("p4_dom0", 32'(qd[0]), 32'd0);
        chk("p4_back", 32'(qat(fdom0, fdom0.size() - 1)), 32'd0);

        // Reset in the middle of a drain with domain 1 owning the queue.
        v0[0] = 1'b0; v1[0] = 1'b1; deq[0] = 1'b1;
        repeat (4) cycle();
        deq[0] = 1'b0;
        repeat (3) cycle();
        v0[0] = 1'b1; v1[0] = 1'b0;
        repeat (2) cycle();
        chk("p5_drain", 32'(dr[0]), 32'd1);
        chk("p5_cur", 32'(qd[0]), 32'd1);
        rst[0] = 1'b1; cycle(); rst[0] = 1'b0;
        chk("p5_rdom", 32'(qd[0]), 32'd0);
        chk("p5_rdrain", 32'(dr[0]), 32'd0);
        chk("p5_grant", 32'(r0r[0]), 32'd1);
        chk("p5_r1", 32'(r1r[0]), 32'd0);
        cycle();

        // Burst limit 1: strict alternation with a gap at each switch.
        for (int i = 0; i < 6; i++)
            chk($sformatf("b1_dom%0d", i), 32'(qat(fdom1, i)), 32'(i % 2));
        for (int i = 1; i < 6; i++)
            chk($sformatf("b1_gap%0d", i), 32'((qat(fcyc1, i) - qat(fcyc1, i - 1)) >= 2), 32'd1);

        // Random traffic on both instances against the model.
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 2; k++) begin
                rst[k] = ($urandom_range(0, 63) == 0);
                v0[k]  = 1'($urandom_range(0, 1));
                v1[k]  = 1'($urandom_range(0, 1));
                m0[k]  = $urandom;
                m1[k]  = $urandom;
                deq[k] = ($urandom_range(0, 3) != 0);
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
